hex_rate_counter: RTL and testbench
===================================

HEX_RATE_COUNTER -- requirements
Module: hex_rate_counter

Interface
REQ-001 SHALL have parameter: CLK_HZ, 50_000_000, clock cycles per second; sets the tick periods.
REQ-002 SHALL have port: CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Enable  input  1  1 = advance on ticks; 0 = hold count and divider state.
REQ-005 SHALL have port: Rate  input  2  tick period select: 00 = 1 cycle, 01 = CLK_HZ, 10 = 2*CLK_HZ, 11 = 4*CLK_HZ cycles.
REQ-006 SHALL have port: Up  input  1  1 = count up, 0 = count down.
REQ-007 SHALL have port: Load  input  1  synchronous parallel-load strobe.
REQ-008 SHALL have port: LoadVal  input  4  value written to Count on Load.
REQ-009 SHALL have port: Count  output  4  registered hex digit, drives the 7-segment hex decoder input directly.
REQ-010 SHALL have port: Tick  output  1  registered; 1-cycle pulse in the cycle Count changes due to counting.
REQ-011 SHALL have port: Wrap  output  1  registered; 1-cycle pulse when Count steps F->0 (up) or 0->F (down).

Function
REQ-012 SHALL contain a divider down-counter, width $clog2(4*CLK_HZ), holding the remaining cycles to the next tick.
REQ-013 SHALL, when Enable=1 and the divider equals 0, generate an internal tick and reload the divider with period-1 for the current Rate.
REQ-014 SHALL, when Enable=1 and the divider is nonzero, decrement the divider by 1.
REQ-015 SHALL, when Rate=00, tick on every enabled cycle (divider stays 0).
REQ-016 SHALL, on an internal tick, update Count to Count+1 (Up=1) or Count-1 (Up=0) modulo 16, asserting Tick together with the new Count.
REQ-017 SHALL assert Wrap only in the cycle Count transitions F->0 while Up=1 or 0->F while Up=0.
REQ-018 SHALL, when Enable=0, hold Count and the divider and keep Tick=0 and Wrap=0.
REQ-019 SHALL register Rate; when the registered and current Rate differ, reload the divider with the new period-1 and suppress the tick in that cycle.
REQ-020 SHALL, on Load=1, set Count=LoadVal and reload the divider with period-1 regardless of Enable; Tick=0 and Wrap=0 that cycle.
REQ-021 SHALL apply priority Reset > Load > Rate change > tick when they coincide.
REQ-022 SHALL sample a change of Up mid-period at the next tick only; the divider is not reloaded.
REQ-023 SHALL produce the first tick after reset or load exactly period cycles later (Rate 01: CLK_HZ enabled cycles).

Reset
REQ-024 SHALL, while Reset=1, force Count=0, Tick=0, Wrap=0, divider=0 and registered Rate=00, asynchronously.
REQ-025 SHALL, on Reset deassertion, load the divider with period-1 for the current Rate on the first clock edge, without a tick.
REQ-026 SHALL abandon any partial period when Reset is asserted mid-count; no tick is issued for it.

Structure
REQ-027 SHALL keep the Rate encodings (RATE_FAST=00, RATE_1X=01, RATE_2X=10, RATE_4X=11) in a shared package, hex_counter_pkg.
REQ-028 SHALL implement the divider as sub-module rate_divider (inputs: clock, reset, enable, rate, reload; output: tick).
REQ-029 SHALL keep the 4-bit up/down counter and the Tick/Wrap registers in hex_rate_counter.

Verification (CLK_HZ=4; periods 1/4/8/16)
REQ-030 SHALL check reset: Reset pulse mid-count -> Count=0, Tick=0 and Wrap=0 immediately, without a clock edge.
REQ-031 SHALL check the 1X rate: Rate=01, Up=1, Enable=1 -> Tick every 4 cycles, Count 0,1,2,...; F->0 with Wrap=1 on the 16th tick.
REQ-032 SHALL check down counting with load: Load with LoadVal=2, then Up=0, Rate=00 -> Count 1,0,F (Wrap=1 at F),E on consecutive cycles.
REQ-033 SHALL check rate change: Rate 01->11 two cycles into a period -> no tick for 16 cycles after the change cycle, then Tick.
REQ-034 SHALL check hold: Enable=0 for 10 cycles mid-period at Rate=10 -> Count frozen; the remaining period completes after re-enable.
REQ-035 SHALL check priority: Load=1, LoadVal=9 in a tick cycle -> Count=9, Tick=0, and the next tick comes a full period later.

Source files
------------

// File: rtl/hex_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_counter_pkg
//  Description : Shared rate-select encodings and tick-period helper for the
//                hex rate counter and its divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_counter_pkg;

    typedef enum logic [1:0] {
        RATE_FAST = 2'b00,  // tick every enabled cycle
        RATE_1X   = 2'b01,  // tick every CLK_HZ cycles
        RATE_2X   = 2'b10,  // tick every 2*CLK_HZ cycles
        RATE_4X   = 2'b11   // tick every 4*CLK_HZ cycles
    } rate_e;

    // Divider reload value (period - 1) for a given rate selection.
    function automatic int unsigned rate_period_m1(input rate_e rate,
                                                   input int unsigned clk_hz);
        int unsigned v;
        v = 0;
        case (rate)
            RATE_FAST: v = 0;
            RATE_1X:   v = clk_hz - 1;
            RATE_2X:   v = 2 * clk_hz - 1;
            default:   v = 4 * clk_hz - 1;
        endcase
        return v;
    endfunction

endpackage : hex_counter_pkg
`default_nettype wire

// File: rtl/rate_divider.sv
`default_nettype none
// ============================================================================
//  Module      : rate_divider
//  Description : Down-counting tick divider. Holds the number of cycles left
//                to the next tick, reloads on explicit reload, on the first
//                edge after reset and on a change of the rate selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_divider
    import hex_counter_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  enable,
    input  rate_e rate,
    input  logic  reload,
    output logic  tick
);

    localparam int c_DIV_W = $clog2(4 * CLK_HZ);

    logic [c_DIV_W-1:0] r_div;
    rate_e              r_rate;
    logic               r_first;    // first edge after reset still pending

    logic [c_DIV_W-1:0] w_period_m1;
    logic               w_rate_chg;
    logic               w_restart;

    assign w_period_m1 = c_DIV_W'(rate_period_m1(rate, CLK_HZ));
    assign w_rate_chg  = (rate != r_rate);
    // Any restart of the period (load, post-reset, rate change) swallows the tick.
    assign w_restart   = reload | r_first | w_rate_chg;
    assign tick        = enable & ~w_restart & (r_div == '0);

    // Divider count, registered rate and post-reset flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_rate  <= RATE_FAST;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            r_rate  <= rate;
            if (w_restart) begin
                r_div <= w_period_m1;
            end else if (enable) begin
                if (r_div == '0) begin
                    r_div <= w_period_m1;
                end else begin
                    r_div <= r_div - c_DIV_W'(1);
                end
            end
        end
    end

endmodule : rate_divider
`default_nettype wire

// File: rtl/hex_rate_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hex_rate_counter
//  Description : 4-bit up/down hex digit counter advancing on divided ticks,
//                with parallel load and registered Tick/Wrap pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_rate_counter
    import hex_counter_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [1:0] Rate,
    input  logic       Up,
    input  logic       Load,
    input  logic [3:0] LoadVal,
    output logic [3:0] Count,
    output logic       Tick,
    output logic       Wrap
);

    logic [3:0] r_count;
    logic       r_tick;
    logic       r_wrap;
    logic       w_div_tick;

    rate_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_rate_divider (
        .clk    (CLOCK_50),
        .rst    (Reset),
        .enable (Enable),
        .rate   (rate_e'(Rate)),
        .reload (Load),
        .tick   (w_div_tick)
    );

    // Digit counter with load priority; Tick/Wrap pulse alongside the new value.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_count <= 4'h0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (Load) begin
                r_count <= LoadVal;
            end else if (w_div_tick) begin
                r_tick <= 1'b1;
                if (Up) begin
                    r_wrap  <= (r_count == 4'hF);
                    r_count <= r_count + 4'd1;
                end else begin
                    r_wrap  <= (r_count == 4'h0);
                    r_count <= r_count - 4'd1;
                end
            end
        end
    end

    assign Count = r_count;
    assign Tick  = r_tick;
    assign Wrap  = r_wrap;

endmodule : hex_rate_counter
`default_nettype wire

// File: tb/tb_hex_rate_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_rate_counter
//  Description : Self-checking bench for hex_rate_counter with CLK_HZ=4
//                (tick periods 1/4/8/16 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_rate_counter;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] rate;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic [3:0] count;
    logic       tick;
    logic       wrap;

    int n_cmp = 0;
    int n_err = 0;

    hex_rate_counter #(
        .CLK_HZ (CLK_HZ)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .Enable   (en),
        .Rate     (rate),
        .Up       (up),
        .Load     (load),
        .LoadVal  (lv),
        .Count    (count),
        .Tick     (tick),
        .Wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] rate;
        logic       up;
        logic       load;
        logic [3:0] lv;
        logic [3:0] cnt;
        logic       tk;
        logic       wr;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] c, input logic t, input logic w);
        check({tag, " count"}, {4'h0, count}, {4'h0, c});
        check({tag, " tick"},  {7'h0, tick},  {7'h0, t});
        check({tag, " wrap"},  {7'h0, wrap},  {7'h0, w});
    endtask

    initial begin
        // en rate up load lv -> cnt tick wrap   (Rate 00: one tick per enabled cycle)
        vecs[0]  = '{1'b1, 2'b00, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0}; // first edge after reset: no tick
        vecs[1]  = '{1'b1, 2'b00, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0}; // load 2
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1}; // 0->F wrap
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'hE, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0}; // disabled: hold
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b00, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0}; // load F
        vecs[11] = '{1'b1, 2'b00, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1}; // F->0 wrap
        vecs[12] = '{1'b1, 2'b00, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 2'b00, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0}; // load while disabled
        vecs[14] = '{1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'hE, 1'b1, 1'b0}; // F->E is not a wrap

        rst = 1'b0; en = 1'b0; rate = 2'b00; up = 1'b1; load = 1'b0; lv = 4'h0;
        #1 rst = 1'b1;
        #1 check_out("reset_state", 4'h0, 1'b0, 1'b0);
        step();
        step();
        check_out("reset_held", 4'h0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 15; i++) begin
            en = vecs[i].en; rate = vecs[i].rate; up = vecs[i].up;
            load = vecs[i].load; lv = vecs[i].lv;
            step();
            check_out($sformatf("row%0d", i), vecs[i].cnt, vecs[i].tk, vecs[i].wr);
        end

        // 1X rate: load 0 with Rate=01, tick every 4 cycles, wrap on 16th tick
        en = 1'b1; up = 1'b1; rate = 2'b01; load = 1'b1; lv = 4'h0;
        step();
        check_out("x1_load", 4'h0, 1'b0, 1'b0);
        load = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step();
            check_out($sformatf("x1_k%0d", k), 4'((k / 4) % 16), (k % 4) == 0, k == 64);
        end

        // Rate change 01 -> 11 two cycles into a period
        step();
        step();
        check_out("rc_pre", 4'h0, 1'b0, 1'b0);
        rate = 2'b11;
        step();
        check_out("rc_change", 4'h0, 1'b0, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            step();
            check_out($sformatf("rc_j%0d", j), (j == 16) ? 4'h1 : 4'h0, j == 16, 1'b0);
        end

        // Hold: Rate=10 (period 8), disable for 10 cycles mid-period
        rate = 2'b10; load = 1'b1; lv = 4'h5;
        step();
        check_out("hold_load", 4'h5, 1'b0, 1'b0);
        load = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step();
            check_out($sformatf("hold_pre%0d", j), 4'h5, 1'b0, 1'b0);
        end
        en = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            check_out($sformatf("hold_off%0d", j), 4'h5, 1'b0, 1'b0);
        end
        en = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            step();
            check_out($sformatf("hold_post%0d", j), (j == 5) ? 4'h6 : 4'h5, j == 5, 1'b0);
        end

        // Priority: load lands in the cycle a tick would occur
        for (int j = 1; j <= 7; j++) begin
            step();
            check_out($sformatf("pri_pre%0d", j), 4'h6, 1'b0, 1'b0);
        end
        load = 1'b1; lv = 4'h9;
        step();
        check_out("pri_load", 4'h9, 1'b0, 1'b0);
        load = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step();
            check_out($sformatf("pri_post%0d", j), (j == 8) ? 4'hA : 4'h9, j == 8, 1'b0);
        end

        // Asynchronous reset right after a tick, no clock edge needed
        rate = 2'b01;
        rst = 1'b1;
        #1 check_out("async_rst", 4'h0, 1'b0, 1'b0);
        step();
        check_out("async_rst_held", 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step();
            check_out($sformatf("post_rst%0d", j), (j == 5) ? 4'h1 : 4'h0, j == 5, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hex_rate_counter
`default_nettype wire
